// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: IDLE/REQ/RESP handshake with lane steering and timeout.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_bus #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_rd_req,
    input  logic        ex_wr_req,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [1:0]  ex_size,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_vld,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err_o,
    output logic        misalign_o
);

    localparam int TW = $clog2(BUS_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic [1:0]     off_q;
    logic           we_q;
    logic [31:0]    rdata_q;
    logic           vld_q;
    logic           err_q;
    logic           done_q;

    logic           req;
    logic           trap;
    logic           go;
    logic           finish;
    logic           tmo;
    logic           at_limit;
    logic [1:0]     off_n;
    logic [3:0]     be_n;
    logic [31:0]    wd_n;

    assign req = ex_rd_req | ex_wr_req;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis;
    logic mis_q;

    assign mis = (ex_size == 2'd1 && ex_addr[0]) ||
                 (ex_size[1] && ex_addr[1:0] != 2'b00);
    assign trap = (state_q == IDLE) && req && !done_q && mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= trap;
    end

    assign misalign_o = mis_q;
`else
    assign trap       = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // done_q blocks re-issue of the request still held during the release cycle
    assign go       = (state_q == IDLE) && req && !trap && !done_q;
    assign at_limit = (cnt_q == TW'(BUS_TIMEOUT - 1));
    assign finish   = (state_q == RESP) && bus_rvalid;
    assign tmo      = (state_q != IDLE) && at_limit && !finish;

    assign stall_o   = (state_q != IDLE) || go;
    assign bus_req   = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign rdata_o   = rdata_q;
    assign rdata_vld = vld_q;
    assign bus_err_o = err_q;

    always_comb begin
        off_n = 2'b00;
        be_n  = 4'b1111;
        wd_n  = ex_wdata;
        unique case (ex_size)
            2'd0: begin
                off_n = ex_addr[1:0];
                be_n  = 4'b0001 << off_n;
                wd_n  = {4{ex_wdata[7:0]}};
            end
            2'd1: begin
                off_n = {ex_addr[1], 1'b0};
                be_n  = 4'b0011 << off_n;
                wd_n  = {2{ex_wdata[15:0]}};
            end
            default: begin
                off_n = 2'b00;
                be_n  = 4'b1111;
                wd_n  = ex_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + TW'(1);
                if (at_limit)     state_d = IDLE;
                else if (bus_gnt) state_d = RESP;
            end
            RESP: begin
                cnt_d = cnt_q + TW'(1);
                if (bus_rvalid || at_limit) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= finish && !we_q;
            err_q   <= tmo;
            done_q  <= finish || tmo;
            if (go) begin
                addr_q  <= {ex_addr[31:2], 2'b00};
                wdata_q <= wd_n;
                be_q    <= be_n;
                off_q   <= off_n;
                we_q    <= ex_wr_req;
            end
            if (finish && !we_q) rdata_q <= bus_rdata >> {off_q, 3'b000};
            else if (tmo)        rdata_q <= '0;
        end
    end

endmodule
